rng_sampler: RTL
================

# rng_sampler

Consumer side of the free-running random-word source. Samples the source's `DBITS`-wide output every enabled cycle and runs a warm-up discard and a repetition-count health test. Accepted words are buffered in a small FIFO and served to the core's entropy/seed CSR path over a valid/ready handshake. A stuck source is latched as a permanent fault until reset.

## Interface
- `DBITS`, 64: width of source words and response data.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `WARMUP`, 8: number of enabled samples discarded after reset; ≥1.
- `REP_LIMIT`, 4: run length of identical consecutive samples that declares a fault; ≥2.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DBITS  source word; may change every cycle; no valid qualifier.
- `enable`  in  1  sample `in_data` this cycle when 1.
- `resp_valid`  out  DBITS→1  head word available.
- `resp_ready`  in  1  consumer accepts head word.
- `resp_data`  out  DBITS  FIFO head word; don't-care when `resp_valid`=0.
- `resp_status`  out  2  0=WARMUP, 1=WAIT (empty), 2=READY, 3=DEAD.
- `fault`  out  1  sticky repetition-test failure.

## Operation
- FSM states WARMUP, RUN, DEAD. Reset enters WARMUP.
  - WARMUP→RUN after `WARMUP` enabled samples.
  - Any state→DEAD on a fault.
  - DEAD is exit-only-by-reset.
- Sampling happens only when `enable`=1. On each sample:
  - `prev` ← `in_data`, `prev_valid` ← 1.
  - `rep` run counter: if `prev_valid` and `in_data==prev`, then `rep`←`rep`+1, else `rep`←0.
- Fault: a sample with `in_data==prev`, `prev_valid`=1 and `rep==REP_LIMIT-2` (i.e. the `REP_LIMIT`-th identical word in a row) sets `fault`. The repetition test runs in WARMUP too.
- Push: a sample is pushed when all of the following hold:
  - state is RUN (the sample completing warm-up is not pushed);
  - no fault this cycle;
  - the sample is not a repeat of `prev`;
  - the FIFO is not full, or a pop occurs in the same cycle.
- A sample that cannot be pushed is dropped silently; `prev`/`rep` still update.
- Pop when `resp_valid && resp_ready`.
- Outputs:
  - `resp_valid` = FIFO non-empty and state≠DEAD.
  - `resp_data` = head entry.
- Status encoding:
  - 3 if DEAD.
  - else 0 if WARMUP.
  - else 2 if non-empty.
  - else 1.
- Entering DEAD flushes the FIFO (count←0). Pops requested in the fault cycle still complete, because `resp_valid` was high.
- Pointers are `log2(DEPTH)` bits wide, wrap modulo `DEPTH`, plus a `log2(DEPTH)+1`-bit occupancy count.

## Timing
- Reset values:
  - `resp_valid`=0, `resp_status`=0, `fault`=0, `resp_data`=0 (storage cleared).
  - `rep`=0, `prev_valid`=0, warm-up counter=0.
- Latency: a word sampled at edge t is visible on `resp_data` with `resp_valid`=1 after edge t (cycle t+1) if the FIFO was empty.
- Throughput: one push and one pop per cycle. Full FIFO plus pop plus push in the same cycle keeps count at `DEPTH`.
- Empty FIFO plus push in the same cycle: no bypass; the word appears the next cycle.
- Fault at edge t: `fault`=1, `resp_valid`=0, `resp_status`=3 from cycle t+1.
- `reset_n` low mid-transfer: all outputs go to reset values immediately (asynchronous). The sample in flight is lost.
- `resp_data` is stable while `resp_valid`=1 and `resp_ready`=0.

## Test plan
- Reset then LFSR stream (taps 0xD800…0, seed all-ones), `enable`=1, `resp_ready`=0:
  - status=0 for 8 cycles;
  - status=2 from cycle 10;
  - FIFO fills with LFSR words 9..12 in order;
  - `resp_valid` stays 1 and `resp_data`=word 9 throughout.
- Same stream with `resp_ready`=1 continuously: one word per cycle, strictly LFSR order from word 9, none skipped, status=2.
- After warm-up, drive constant 0x5A for 4 enabled cycles:
  - first word pushed, repeats not pushed;
  - 4th sample raises `fault`;
  - next cycle `resp_valid`=0, status=3;
  - stays DEAD after stream resumes until `reset_n` is pulsed, then status=0.
- Full FIFO with `resp_ready`=1 and a new distinct sample in the same cycle: count stays 4, head advances, new word lands at the tail.
- Toggle `enable` 1/0 during warm-up: the WARMUP→RUN transition occurs after exactly 8 enabled samples. Disabled cycles with repeated `in_data` neither count toward warm-up nor increment `rep`.
- Assert `reset_n`=0 asynchronously mid-cycle with the FIFO holding 3 words: `resp_valid` drops before the next edge, status=0, and `fault`=0 after release.

Source files
------------

// File: rtl/rng_sampler.sv
// Samples a free-running random-word source, discards a warm-up window, runs a
// repetition-count health test and buffers accepted words in a small FIFO.
module rng_sampler #(
    parameter int DBITS     = 64,
    parameter int DEPTH     = 4,
    parameter int WARMUP    = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [DBITS-1:0] in_data,
    input  logic             enable,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DBITS-1:0] resp_data,
    output logic [1:0]       resp_status,
    output logic             fault,
    output logic [1:0]       dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WARMUP + 1);
    localparam int RW = $clog2(REP_LIMIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [RW-1:0] REP_TRIP = RW'(REP_LIMIT - 2);
    localparam logic [RW-1:0] REP_SAT = RW'(REP_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    state_t           state;
    logic [DBITS-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WW-1:0]    warm_cnt;
    logic [RW-1:0]    rep;
    logic [DBITS-1:0] prev;
    logic             prev_valid;

    logic is_rep;
    logic fault_now;
    logic full;
    logic pop;
    logic push;

    // Handshake: a word transfers on every rising edge where resp_valid and
    // resp_ready are both 1; resp_data holds the head until that edge and
    // resp_valid never depends on resp_ready.
    always_comb begin
        is_rep    = enable && prev_valid && (in_data == prev);
        fault_now = is_rep && (rep == REP_TRIP);
        full      = (count == FULL_CNT);
        pop       = resp_valid && resp_ready;
        push      = enable && (state == ST_RUN) && !fault_now && !is_rep
                    && (!full || pop);
    end

    assign resp_valid = (count != '0) && (state != ST_DEAD);
    assign resp_data  = mem[rd_ptr];
    assign dbg_state  = state;

    always_comb begin
        resp_status = 2'd1;
        if (state == ST_DEAD)        resp_status = 2'd3;
        else if (state == ST_WARMUP) resp_status = 2'd0;
        else if (count != '0)        resp_status = 2'd2;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_WARMUP;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            warm_cnt   <= '0;
            rep        <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            fault      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enable) begin
                prev       <= in_data;
                prev_valid <= 1'b1;
                // Saturation only matters once DEAD, where the run keeps growing.
                if (!is_rep)             rep <= '0;
                else if (rep != REP_SAT) rep <= rep + RW'(1);
            end

            if (enable && state == ST_WARMUP) begin
                if (warm_cnt == WARM_LAST) state <= ST_RUN;
                else                       warm_cnt <= warm_cnt + WW'(1);
            end

            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);

            if (fault_now) begin
                // Sticky: the FIFO is flushed and only reset leaves DEAD.
                fault <= 1'b1;
                state <= ST_DEAD;
                count <= '0;
            end else if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule
